halfword_memory_responder: RTL and testbench
============================================

# halfword_memory_responder

Memory-side responder for the 16-bit halfword memory bus driven by the CPU memory interface. It holds a synchronous 16-bit-wide RAM, accepts single-cycle read/write commands, and returns read data through a fixed-latency pipeline with a valid strobe. It sits between the memory interface and the storage array, and is also the bench memory model for interface verification. It additionally flags illegal commands and keeps saturating access counters for debug.

## Interface
- ADDR_WIDTH, 12: halfword address width.
- DEPTH, 4096: number of 16-bit words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read command to `data_valid`; legal range 1..4.
- COUNT_WIDTH, 16: width of the access counters.

- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  Synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- mem_enable  input  1  command qualifier; no access when 0.
- read_enable  input  1  read request (qualified by mem_enable).
- write_enable  input  1  write request (qualified by mem_enable).
- address  input  ADDR_WIDTH  halfword address.
- data_in  input  16  write data.
- data_out  output  16  read data; holds last returned value.
- data_valid  output  1  one-cycle strobe; data_out carries a new read result.
- access_error  output  1  sticky flag for an illegal command.
- read_count  output  COUNT_WIDTH  accepted reads, saturating.
- write_count  output  COUNT_WIDTH  accepted writes, saturating.

## Operation
- Command decode, sampled each rising edge:
  - mem_enable=0: idle, no side effects.
  - mem_enable=1, read_enable=1, write_enable=0: READ.
  - mem_enable=1, write_enable=1, read_enable=0: WRITE.
  - mem_enable=1 with both enables 1: ILLEGAL.
  - mem_enable=1 with both enables 0: idle.
- WRITE:
  - mem[address] <= data_in at the sampling edge.
  - write_count += 1, saturating at all-ones.
- READ:
  - mem[address] is sampled at the edge and enters a READ_LATENCY-deep pipeline of {valid, data}.
  - read_count += 1, saturating.
- ILLEGAL:
  - No array write; nothing enters the read pipeline; counters unchanged.
  - access_error <= 1; it stays 1 until reset.
- Address range:
  - Address ≥ DEPTH is out of range: a write is dropped, a read returns 16'h0000 with a normal valid.
  - Out-of-range accesses still count and are not errors.
  - No address wrap inside the block; the address width bounds the range.
- Pipeline output:
  - Pipeline stage READ_LATENCY drives data_valid.
  - data_out updates only when a valid result exits the pipeline; otherwise it holds.
- Ordering:
  - Read-after-write to the same address in a later cycle returns the new data.
  - One command per cycle; back-to-back reads give back-to-back valids in issue order.
- No backpressure: the consumer must accept data when data_valid=1.
- Reset (reset=0 at an edge):
  - data_out=0, data_valid=0, all pipeline valids=0, access_error=0, read_count=0, write_count=0.
  - Array contents are not reset. Commands sampled during reset are ignored.
  - Reads in flight when reset asserts are discarded: no data_valid for them after reset releases.

## Timing
- Read command sampled at edge N -> data_valid=1 and data_out valid during cycle N+READ_LATENCY (after edge N+READ_LATENCY-1 for READ_LATENCY=1 means visible right after edge N).
- Write takes effect at edge N; a read sampled at edge N+1 or later sees it.
- access_error rises in the cycle following the illegal edge.
- Counters update in the cycle following the accepting edge.
- Throughput: one access per cycle, no stalls.

## Test plan
- WRITE 0x1234 to 0x005, then READ 0x005 next cycle (READ_LATENCY=1) -> data_valid pulses one cycle after the read edge with data_out=0x1234; write_count=1, read_count=1.
- READ_LATENCY=3, four consecutive reads of 0x010..0x013 preloaded with 0xA0..0xA3 -> four consecutive valids starting 3 cycles after the first read, data in order 0xA0..0xA3.
- mem_enable=1 with read_enable=1 and write_enable=1 at address 0x020 holding 0xBEEF, data_in=0x0000 -> access_error=1 and sticky; no data_valid; a later read of 0x020 returns 0xBEEF; counters unchanged.
- READ_LATENCY=3: issue a read, assert reset 1 cycle later for 1 cycle -> data_valid never pulses; data_out=0; counters=0; array contents preserved on a later read.
- COUNT_WIDTH=4: 20 writes -> write_count saturates at 0xF and does not wrap to 0.
- DEPTH=2048: write to 0x900, then read 0x900 -> data_out=0x0000 with data_valid; the write is dropped and access_error stays 0.

Source files
------------

// File: rtl/halfword_memory_responder.sv
// Halfword (16-bit) memory responder: synchronous RAM with single-cycle commands,
// fixed-latency read return, sticky illegal-command flag and saturating access counters.
module halfword_memory_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_enable,
    input  logic                   read_enable,
    input  logic                   write_enable,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [15:0]            data_in,
    output logic [15:0]            data_out,
    output logic                   data_valid,
    output logic                   access_error,
    output logic [COUNT_WIDTH-1:0] read_count,
    output logic [COUNT_WIDTH-1:0] write_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [15:0] mem [DEPTH];

    logic        rd_cmd;
    logic        wr_cmd;
    logic        bad_cmd;
    logic        in_range;
    logic [15:0] rd_data;

    // Stage k of the read pipeline lives at index k-1; the last stage is the output register.
    logic [READ_LATENCY-1:0]        pipe_valid;
    logic [READ_LATENCY-1:0][15:0]  pipe_data;
    logic [READ_LATENCY:0]          valid_chain;
    logic [READ_LATENCY:0][15:0]    data_chain;

    always_comb begin
        rd_cmd   = mem_enable &  read_enable & ~write_enable;
        wr_cmd   = mem_enable & ~read_enable &  write_enable;
        bad_cmd  = mem_enable &  read_enable &  write_enable;
        in_range = ({1'b0, address} < DEPTH_LIMIT);
        rd_data  = in_range ? mem[address[IDX_W-1:0]] : 16'h0000;
    end

    assign valid_chain = {pipe_valid, rd_cmd};
    assign data_chain  = {pipe_data, rd_data};

    // NOTE: the storage array has no reset; only the control state around it is cleared.
    always_ff @(posedge clk) begin
        if (reset && wr_cmd && in_range) begin
            mem[address[IDX_W-1:0]] <= data_in;
        end
    end

    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_valid   <= '0;
            pipe_data    <= '0;
            access_error <= 1'b0;
            read_count   <= '0;
            write_count  <= '0;
        end else begin
            pipe_valid <= valid_chain[READ_LATENCY-1:0];
            // Inner stages shift freely; the final stage only loads a real result.
            for (int k = 0; k < READ_LATENCY; k++) begin
                if (k != READ_LATENCY - 1 || valid_chain[k]) begin
                    pipe_data[k] <= data_chain[k];
                end
            end
            if (bad_cmd) begin
                access_error <= 1'b1;
            end
            if (rd_cmd && read_count != '1) begin
                read_count <= read_count + COUNT_WIDTH'(1);
            end
            if (wr_cmd && write_count != '1) begin
                write_count <= write_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign data_valid = pipe_valid[READ_LATENCY-1];
    assign data_out   = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_halfword_memory_responder.sv
// Bench for halfword_memory_responder: two configurations share one command stream and are
// checked against a queue-based reference model, a directed vector table and corner sequences.
module tb_halfword_memory_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] data_in = '0;

    logic [15:0] a_dout, b_dout;
    logic        a_valid, b_valid, a_err, b_err;
    logic [3:0]  a_rc, a_wc;
    logic [15:0] b_rc, b_wc;

    always #5 clk = ~clk;

    // Configuration A: small depth, single-cycle latency, 4-bit counters.
    halfword_memory_responder #(
        .ADDR_WIDTH(12), .DEPTH(2048), .READ_LATENCY(1), .COUNT_WIDTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .mem_enable(mem_enable), .read_enable(read_enable),
        .write_enable(write_enable), .address(address), .data_in(data_in),
        .data_out(a_dout), .data_valid(a_valid), .access_error(a_err),
        .read_count(a_rc), .write_count(a_wc)
    );

    // Configuration B: full depth, three-cycle latency, 16-bit counters.
    halfword_memory_responder #(
        .ADDR_WIDTH(12), .DEPTH(4096), .READ_LATENCY(3), .COUNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .reset(reset), .mem_enable(mem_enable), .read_enable(read_enable),
        .write_enable(write_enable), .address(address), .data_in(data_in),
        .data_out(b_dout), .data_valid(b_valid), .access_error(b_err),
        .read_count(b_rc), .write_count(b_wc)
    );

    logic [31:0] act_valid [2];
    logic [31:0] act_dout  [2];
    logic [31:0] act_err   [2];
    logic [31:0] act_rc    [2];
    logic [31:0] act_wc    [2];

    assign act_valid[0] = {31'd0, a_valid};
    assign act_valid[1] = {31'd0, b_valid};
    assign act_dout[0]  = {16'd0, a_dout};
    assign act_dout[1]  = {16'd0, b_dout};
    assign act_err[0]   = {31'd0, a_err};
    assign act_err[1]   = {31'd0, b_err};
    assign act_rc[0]    = {28'd0, a_rc};
    assign act_rc[1]    = {16'd0, b_rc};
    assign act_wc[0]    = {28'd0, a_wc};
    assign act_wc[1]    = {16'd0, b_wc};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending reads are a queue of {dut, due cycle, data}; memory is sparse.
    typedef struct {
        int          dut;
        int          due;
        bit          known;
        logic [15:0] data;
    } rd_t;

    rd_t         pend[$];
    logic [15:0] mmem[int];
    int          depth_m [2] = '{2048, 4096};
    int          lat_m   [2] = '{1, 3};
    int          cmax_m  [2] = '{15, 65535};
    bit          exp_valid  [2];
    logic [15:0] exp_dout   [2];
    bit          dout_known [2];
    bit          exp_err    [2];
    int          exp_rc     [2];
    int          exp_wc     [2];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int key;
            key = d * 65536 + int'(address);
            if (!reset) begin
                exp_err[d]    = 1'b0;
                exp_rc[d]     = 0;
                exp_wc[d]     = 0;
                exp_dout[d]   = 16'h0000;
                dout_known[d] = 1'b1;
            end else if (mem_enable && read_enable && write_enable) begin
                exp_err[d] = 1'b1;
            end else if (mem_enable && write_enable) begin
                if (int'(address) < depth_m[d]) mmem[key] = data_in;
                if (exp_wc[d] < cmax_m[d]) exp_wc[d]++;
            end else if (mem_enable && read_enable) begin
                rd_t e;
                e.dut = d;
                e.due = cyc + lat_m[d] - 1;
                if (int'(address) >= depth_m[d]) begin
                    e.known = 1'b1;
                    e.data  = 16'h0000;
                end else if (mmem.exists(key)) begin
                    e.known = 1'b1;
                    e.data  = mmem[key];
                end else begin
                    e.known = 1'b0;
                    e.data  = 16'h0000;
                end
                pend.push_back(e);
                if (exp_rc[d] < cmax_m[d]) exp_rc[d]++;
            end
        end
        if (!reset) begin
            pend.delete();
            armed = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            int idx;
            idx = -1;
            exp_valid[d] = 1'b0;
            foreach (pend[i]) if (idx < 0 && pend[i].dut == d) idx = i;
            if (idx >= 0 && pend[idx].due == cyc) begin
                exp_valid[d]  = 1'b1;
                exp_dout[d]   = pend[idx].data;
                dout_known[d] = pend[idx].known;
                pend.delete(idx);
            end
        end
    endtask

    task automatic compare_model();
        if (!armed) return;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_valid_%0d", d), act_valid[d], {31'd0, exp_valid[d]});
            if (dout_known[d]) check($sformatf("model_dout_%0d", d), act_dout[d], {16'd0, exp_dout[d]});
            check($sformatf("model_err_%0d", d), act_err[d], {31'd0, exp_err[d]});
            check($sformatf("model_rc_%0d", d), act_rc[d], exp_rc[d]);
            check($sformatf("model_wc_%0d", d), act_wc[d], exp_wc[d]);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample 1ns later.
    task automatic step(input bit r, input bit me, input bit re, input bit we,
                        input logic [11:0] a, input logic [15:0] din);
        @(negedge clk);
        reset        = r;
        mem_enable   = me;
        read_enable  = re;
        write_enable = we;
        address      = a;
        data_in      = din;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          r, me, re, we;
        logic [11:0] a;
        logic [15:0] din;
        bit          ev;
        logic [15:0] ed;
        bit          ee;
        logic [3:0]  erc, ewc;
    } vec_t;

    initial begin
        vec_t        tbl [13];
        bit          lat_ev [8];
        logic [15:0] lat_ed [8];

        // Expected values for configuration A after each edge.
        tbl[0]  = '{1, 1, 0, 1, 12'h005, 16'h1234, 0, 16'h0000, 0, 4'd0, 4'd1};
        tbl[1]  = '{1, 1, 1, 0, 12'h005, 16'h0000, 1, 16'h1234, 0, 4'd1, 4'd1};
        tbl[2]  = '{1, 0, 1, 1, 12'h005, 16'hFFFF, 0, 16'h1234, 0, 4'd1, 4'd1};
        tbl[3]  = '{1, 1, 0, 1, 12'h020, 16'hBEEF, 0, 16'h1234, 0, 4'd1, 4'd2};
        tbl[4]  = '{1, 1, 1, 1, 12'h020, 16'h0000, 0, 16'h1234, 1, 4'd1, 4'd2};
        tbl[5]  = '{1, 1, 0, 0, 12'h020, 16'h0000, 0, 16'h1234, 1, 4'd1, 4'd2};
        tbl[6]  = '{1, 1, 1, 0, 12'h020, 16'h0000, 1, 16'hBEEF, 1, 4'd2, 4'd2};
        tbl[7]  = '{1, 1, 0, 1, 12'h900, 16'h5A5A, 0, 16'hBEEF, 1, 4'd2, 4'd3};
        tbl[8]  = '{1, 1, 1, 0, 12'h900, 16'h0000, 1, 16'h0000, 1, 4'd3, 4'd3};
        tbl[9]  = '{0, 1, 1, 0, 12'h005, 16'h0000, 0, 16'h0000, 0, 4'd0, 4'd0};
        tbl[10] = '{1, 1, 1, 0, 12'h005, 16'h0000, 1, 16'h1234, 0, 4'd1, 4'd0};
        tbl[11] = '{1, 1, 0, 1, 12'h901, 16'h1111, 0, 16'h1234, 0, 4'd1, 4'd1};
        tbl[12] = '{1, 1, 1, 0, 12'h901, 16'h0000, 1, 16'h0000, 0, 4'd2, 4'd1};

        lat_ev = '{0, 0, 1, 1, 1, 1, 0, 0};
        lat_ed = '{16'h0000, 16'h0000, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A3, 16'h00A3};

        step(0, 0, 0, 0, 12'h000, 16'h0000);
        step(0, 0, 0, 0, 12'h000, 16'h0000);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].me, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].din);
            check($sformatf("vec%0d_valid", i), {31'd0, a_valid}, {31'd0, tbl[i].ev});
            check($sformatf("vec%0d_dout", i), {16'd0, a_dout}, {16'd0, tbl[i].ed});
            check($sformatf("vec%0d_err", i), {31'd0, a_err}, {31'd0, tbl[i].ee});
            check($sformatf("vec%0d_rc", i), {28'd0, a_rc}, {28'd0, tbl[i].erc});
            check($sformatf("vec%0d_wc", i), {28'd0, a_wc}, {28'd0, tbl[i].ewc});
        end

        // Back-to-back reads through the three-stage pipeline.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 12'(16 + i), 16'(160 + i));
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1, 1, 1, 0, 12'(16 + i), 16'h0000);
            else       step(1, 0, 0, 0, 12'h000, 16'h0000);
            check($sformatf("lat3_valid_%0d", i), {31'd0, b_valid}, {31'd0, lat_ev[i]});
            if (i >= 2) check($sformatf("lat3_dout_%0d", i), {16'd0, b_dout}, {16'd0, lat_ed[i]});
        end

        // Read in flight when reset asserts must never produce a valid.
        step(1, 1, 1, 0, 12'h010, 16'h0000);
        check("flush_valid_issue", {31'd0, b_valid}, 32'd0);
        step(0, 0, 0, 0, 12'h000, 16'h0000);
        check("flush_dout_reset", {16'd0, b_dout}, 32'd0);
        check("flush_rc_reset", {16'd0, b_rc}, 32'd0);
        check("flush_wc_reset", {16'd0, b_wc}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 12'h000, 16'h0000);
            check($sformatf("flush_valid_%0d", i), {31'd0, b_valid}, 32'd0);
        end
        step(1, 1, 1, 0, 12'h010, 16'h0000);
        step(1, 0, 0, 0, 12'h000, 16'h0000);
        check("reread_early", {31'd0, b_valid}, 32'd0);
        step(1, 0, 0, 0, 12'h000, 16'h0000);
        check("reread_valid", {31'd0, b_valid}, 32'd1);
        check("reread_dout", {16'd0, b_dout}, 32'h00A0);

        // Write counter saturation on the 4-bit configuration.
        step(0, 0, 0, 0, 12'h000, 16'h0000);
        for (int n = 1; n <= 20; n++) begin
            step(1, 1, 0, 1, 12'(48 + n % 8), 16'(n));
            check($sformatf("sat_wc_%0d", n), {28'd0, a_wc}, (n < 15) ? n : 15);
        end

        // Preload every address the random phase touches, then run random traffic.
        for (int i = 0; i < 64; i++) step(1, 1, 0, 1, 12'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 12'(12'h900 + i), 16'($urandom));
        for (int i = 0; i < 600; i++) begin
            bit          r, me, re, we;
            int          kind;
            logic [11:0] a;
            r    = ($urandom_range(0, 39) != 0);
            kind = $urandom_range(0, 99);
            a    = ($urandom_range(0, 3) == 0) ? 12'(12'h900 + $urandom_range(0, 15))
                                               : 12'($urandom_range(0, 63));
            me = 1'b1; re = 1'b0; we = 1'b0;
            if (kind < 40)      re = 1'b1;
            else if (kind < 70) we = 1'b1;
            else if (kind < 73) begin re = 1'b1; we = 1'b1; end
            else if (kind >= 85) begin
                me = 1'b0;
                re = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1));
            end
            step(r, me, re, we, a, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
